// File: rtl/vc_arbiter_pkg.sv
// Shared transmission-layer definitions for the VC read-side arbiter.
// Holds the state encoding, the destination-select bit and default parameters.
package vc_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 6;
  localparam int unsigned VC0_WEIGHT_DEFAULT = 4;
  localparam int unsigned RUN_WIDTH          = 4;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_e;

  // One in-flight pop: valid bit plus the source VC (0 = VC0, 1 = VC1).
  typedef struct packed {
    logic valid;
    logic src;
  } pipe_stage_t;

  // Word MSB selects the destination FIFO (0 = D0, 1 = D1).
  function automatic int unsigned dest_bit(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/vc_wrr_grant.sv
// Weighted round-robin pop decision between VC0 and VC1.
// Grants are combinational so a pop reacts to the current empty/almost-full flags.
module vc_wrr_grant
  import vc_arbiter_pkg::*;
#(
  parameter int unsigned VC0_WEIGHT = VC0_WEIGHT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic allow,
  input  logic empty_vc0,
  input  logic empty_vc1,
  output logic grant_vc0_c,
  output logic grant_vc1_c
);

  localparam logic [RUN_WIDTH-1:0] WEIGHT = RUN_WIDTH'(VC0_WEIGHT);

  logic [RUN_WIDTH-1:0] vc0_run_q;
  logic [RUN_WIDTH-1:0] vc0_run_d;
  logic                 run_at_weight;

  assign run_at_weight = (vc0_run_q >= WEIGHT);

  // VC0 wins contention until it has used its weight of consecutive grants.
  always_comb begin
    grant_vc0_c = 1'b0;
    grant_vc1_c = 1'b0;
    if (allow) begin
      if (!empty_vc0 && !empty_vc1) begin
        if (run_at_weight) begin
          grant_vc1_c = 1'b1;
        end else begin
          grant_vc0_c = 1'b1;
        end
      end else if (!empty_vc0) begin
        grant_vc0_c = 1'b1;
      end else if (!empty_vc1) begin
        grant_vc1_c = 1'b1;
      end
    end
  end

  always_comb begin
    vc0_run_d = vc0_run_q;
    if (flush || empty_vc1 || grant_vc1_c) begin
      vc0_run_d = '0;
    end else if (grant_vc0_c && !run_at_weight) begin
      vc0_run_d = vc0_run_q + RUN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc0_run_q <= '0;
    end else begin
      vc0_run_q <= vc0_run_d;
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Drains the VC0/VC1 FIFOs and forwards each word to D0 or D1 by its MSB.
// Pop in cycle N, FIFO data valid in N+1, push presented in N+2.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEFAULT,
  parameter int unsigned VC0_WEIGHT = VC0_WEIGHT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  almost_full_fifo_D0,
  input  logic                  almost_full_fifo_D1,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out_arb,
  output logic                  idle_arb
);

  localparam int unsigned DEST_BIT = dest_bit(data_width);

  arb_state_e            state_q, state_d;
  pipe_stage_t           s1_q, s1_d;
  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  idle_q, idle_d;

  logic                  grant_allow_c;
  logic                  grant_vc0_c;
  logic                  grant_vc1_c;
  logic                  any_grant_c;
  logic                  pipe_busy_c;
  logic [data_width-1:0] cap_word_c;

  // Destination is unknown before the pop, so either almost-full stalls all pops.
  assign grant_allow_c = init && (state_q != ST_INIT)
                      && !almost_full_fifo_D0 && !almost_full_fifo_D1;

  vc_wrr_grant #(
    .VC0_WEIGHT(VC0_WEIGHT)
  ) u_grant (
    .clk        (clk),
    .rst        (reset),
    .flush      (!init),
    .allow      (grant_allow_c),
    .empty_vc0  (empty_fifo_VC0),
    .empty_vc1  (empty_fifo_VC1),
    .grant_vc0_c(grant_vc0_c),
    .grant_vc1_c(grant_vc1_c)
  );

  assign any_grant_c = grant_vc0_c | grant_vc1_c;
  assign pipe_busy_c = s1_q.valid | push_d0_q | push_d1_q;
  assign cap_word_c  = s1_q.src ? data_out_VC1 : data_out_VC0;

  always_comb begin
    state_d   = state_q;
    s1_d      = '0;
    push_d0_d = 1'b0;
    push_d1_d = 1'b0;
    data_d    = data_q;
    idle_d    = 1'b0;

    if (!init) begin
      // Flush: in-flight words are dropped and the output word returns to 0.
      state_d = ST_INIT;
      data_d  = '0;
    end else begin
      unique case (state_q)
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (any_grant_c) state_d = ST_ACTIVE;
        ST_ACTIVE: if (!any_grant_c && !pipe_busy_c) state_d = ST_IDLE;
        default:   state_d = ST_INIT;
      endcase

      s1_d.valid = any_grant_c;
      s1_d.src   = grant_vc1_c;

      if (s1_q.valid) begin
        data_d    = cap_word_c;
        push_d0_d = !cap_word_c[DEST_BIT];
        push_d1_d =  cap_word_c[DEST_BIT];
      end
    end

    idle_d = empty_fifo_VC0 && empty_fifo_VC1 && !any_grant_c && !pipe_busy_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      s1_q      <= '0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_q    <= data_d;
      idle_q    <= idle_d;
    end
  end

  // Pops follow the current flags; pushes are masked the moment init drops.
  assign rd_enable_VC0 = grant_vc0_c;
  assign rd_enable_VC1 = grant_vc1_c;
  assign push_D0       = push_d0_q & init;
  assign push_D1       = push_d1_q & init;
  assign data_out_arb  = data_q;
  assign idle_arb      = idle_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Scoreboard bench for vc_arbiter: behavioural VC FIFOs feed the DUT,
// expected pushes are queued per test and a monitor compares every push.
module tb_vc_arbiter;
  import vc_arbiter_pkg::*;

  localparam int unsigned DW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          e0, e1;
  logic [DW-1:0] dout0, dout1;
  logic          af0, af1;
  logic          rd0, rd1, push0, push1, idle;
  logic [DW-1:0] data_arb;

  always #5 clk = ~clk;

  vc_arbiter #(.data_width(DW), .VC0_WEIGHT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .init               (init),
    .empty_fifo_VC0     (e0),
    .empty_fifo_VC1     (e1),
    .data_out_VC0       (dout0),
    .data_out_VC1       (dout1),
    .almost_full_fifo_D0(af0),
    .almost_full_fifo_D1(af1),
    .rd_enable_VC0      (rd0),
    .rd_enable_VC1      (rd1),
    .push_D0            (push0),
    .push_D1            (push1),
    .data_out_arb       (data_arb),
    .idle_arb           (idle)
  );

  typedef struct packed {
    logic          dest;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] q0[$], q1[$];
  logic          ld0_v = 1'b0, ld1_v = 1'b0;
  logic [DW-1:0] ld0_d = '0, ld1_d = '0;
  int            cyc = 0;
  int            checks = 0, errors = 0;
  int            pop_vc[$], pop_cyc[$], push_cyc[$];
  int            seq_b[20] = '{0,0,0,0,1,0,0,0,0,1,0,0,1,1,1,1,1,1,1,1};

  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFO model: registered read data, count updates at the pop edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      dout0 <= '0;
      dout1 <= '0;
      e0    <= 1'b1;
      e1    <= 1'b1;
    end else begin
      if (rd0 && q0.size() > 0) dout0 <= q0.pop_front();
      else if (!init)           dout0 <= '0;
      if (rd1 && q1.size() > 0) dout1 <= q1.pop_front();
      else if (!init)           dout1 <= '0;
      if (ld0_v) q0.push_back(ld0_d);
      if (ld1_v) q1.push_back(ld1_d);
      e0 <= (q0.size() == 0);
      e1 <= (q1.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rd0 || rd1) begin
        checks++;
        if (rd0 && rd1) begin
          errors++;
          $display("FAIL both_rd cycle=%0d rd0=%0b rd1=%0b required one", cyc, rd0, rd1);
        end else if ((rd0 && e0) || (rd1 && e1)) begin
          errors++;
          $display("FAIL over_read cycle=%0d rd0=%0b e0=%0b rd1=%0b e1=%0b", cyc, rd0, e0, rd1, e1);
        end
        pop_vc.push_back(rd1 ? 1 : 0);
        pop_cyc.push_back(cyc);
      end
      if (push0 || push1) begin
        checks++;
        push_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_push cycle=%0d push0=%0b push1=%0b data=%h required none",
                   cyc, push0, push1, data_arb);
        end else begin
          mon_e = exp_q.pop_front();
          if ((push0 && push1) || (push1 != mon_e.dest) || (data_arb != mon_e.data)) begin
            errors++;
            $display("FAIL push cycle=%0d actual push0=%0b push1=%0b data=%h required dest=D%0d data=%h",
                     cyc, push0, push1, data_arb, mon_e.dest, mon_e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int at_or(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic expect_push(input logic [DW-1:0] w);
    exp_t e;
    e.dest = w[DW-1];
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic v0, input logic [DW-1:0] w0,
                      input logic v1, input logic [DW-1:0] w1);
    ld0_v = v0; ld0_d = w0;
    ld1_v = v1; ld1_d = w1;
    tick();
    ld0_v = 1'b0;
    ld1_v = 1'b0;
  endtask

  task automatic clear_logs();
    pop_vc.delete();
    pop_cyc.delete();
    push_cyc.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    repeat (3) tick();
    while (!idle && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(idle), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd0"}, int'(rd0), 0);
    check({tag, "_rd1"}, int'(rd1), 0);
    check({tag, "_push0"}, int'(push0), 0);
    check({tag, "_push1"}, int'(push1), 0);
    check({tag, "_data"}, int'(data_arb), 0);
    check({tag, "_idle"}, int'(idle), 1);
  endtask

  initial begin
    int base, rise, fall, kcyc;
    logic [DW-1:0] wa[10], wb[10], w;
    int ia, ib;

    reset = 1'b1; init = 1'b0; af0 = 1'b0; af1 = 1'b0;
    tick();
    check_reset_outputs("por");
    tick();
    reset = 1'b0;
    tick();
    init = 1'b1;
    af0  = 1'b1;
    tick();

    // VC0 only: 05, 21, 0A back to back
    clear_logs();
    load(1'b1, 6'h05, 1'b0, '0);
    load(1'b1, 6'h21, 1'b0, '0);
    load(1'b1, 6'h0A, 1'b0, '0);
    exp_q.push_back('{dest: 1'b0, data: 6'h05});
    exp_q.push_back('{dest: 1'b1, data: 6'h21});
    exp_q.push_back('{dest: 1'b0, data: 6'h0A});
    af0  = 1'b0;
    base = cyc;
    wait_idle("a_idle", 20);
    check("a_pops", pop_vc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("a_pop_vc", at_or(pop_vc, i), 0);
      check("a_pop_cyc", at_or(pop_cyc, i), base + i);
      check("a_push_cyc", at_or(push_cyc, i), base + i + 2);
    end
    check("a_left", exp_q.size(), 0);

    // Both VCs with 10 words: VC0 x4, VC1 x1 pattern
    af0 = 1'b1;
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      wa[i] = DW'(i * 5 + 1);
      wb[i] = DW'(56 - i * 3);
      load(1'b1, wa[i], 1'b1, wb[i]);
    end
    ia = 0; ib = 0;
    for (int i = 0; i < 20; i++) begin
      if (seq_b[i] == 0) begin w = wa[ia]; ia++; end
      else               begin w = wb[ib]; ib++; end
      expect_push(w);
    end
    af0  = 1'b0;
    base = cyc;
    wait_idle("b_idle", 60);
    check("b_pops", pop_vc.size(), 20);
    for (int i = 0; i < 20; i++) check("b_grant_seq", at_or(pop_vc, i), seq_b[i]);
    check("b_last_pop_cyc", at_or(pop_cyc, 19), base + 19);
    check("b_left", exp_q.size(), 0);

    // almost_full_D1 during a continuous stream
    af0 = 1'b1;
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      w = DW'(i * 9 + 2);
      load(1'b1, w, 1'b0, '0);
      expect_push(w);
    end
    af0  = 1'b0;
    base = cyc;
    repeat (3) tick();
    af1  = 1'b1;
    rise = cyc;
    repeat (4) tick();
    af1  = 1'b0;
    fall = cyc;
    wait_idle("c_idle", 30);
    check("c_pops", pop_vc.size(), 8);
    check("c_last_pop_before", at_or(pop_cyc, 2), rise - 1);
    check("c_resume_pop", at_or(pop_cyc, 3), fall);
    check("c_inflight1", at_or(push_cyc, 1), rise);
    check("c_inflight2", at_or(push_cyc, 2), rise + 1);
    check("c_next_push", at_or(push_cyc, 3), fall + 2);
    check("c_left", exp_q.size(), 0);

    // init dropped with two words in flight
    af0 = 1'b1;
    clear_logs();
    wa[0] = 6'h03; wa[1] = 6'h24; wa[2] = 6'h15;
    wa[3] = 6'h36; wa[4] = 6'h07; wa[5] = 6'h28;
    for (int i = 0; i < 6; i++) load(1'b1, wa[i], 1'b0, '0);
    expect_push(wa[0]);
    expect_push(wa[3]);
    expect_push(wa[4]);
    expect_push(wa[5]);
    af0  = 1'b0;
    base = cyc;
    repeat (3) tick();
    init = 1'b0;
    kcyc = cyc;
    tick();
    check("d_state_init", int'(dut.state_q), int'(ST_INIT));
    check("d_data_zero", int'(data_arb), 0);
    tick();
    init = 1'b1;
    wait_idle("d_idle", 30);
    check("d_pops", pop_vc.size(), 6);
    check("d_first_push", at_or(push_cyc, 0), base + 2);
    check("d_resume_pop", at_or(pop_cyc, 3), kcyc + 3);
    check("d_resume_push", at_or(push_cyc, 1), kcyc + 5);
    check("d_left", exp_q.size(), 0);

    // Last VC1 word popped while VC0 fills in the same cycle
    af0 = 1'b1;
    clear_logs();
    load(1'b0, '0, 1'b1, 6'h2B);
    expect_push(6'h2B);
    expect_push(6'h11);
    af0  = 1'b0;
    base = cyc;
    load(1'b1, 6'h11, 1'b0, '0);
    wait_idle("e_idle", 20);
    check("e_pops", pop_vc.size(), 2);
    check("e_first_vc1", at_or(pop_vc, 0), 1);
    check("e_then_vc0", at_or(pop_vc, 1), 0);
    check("e_vc0_cyc", at_or(pop_cyc, 1), base + 1);
    check("e_left", exp_q.size(), 0);

    // Reset asserted mid-stream
    af0 = 1'b1;
    clear_logs();
    for (int i = 0; i < 6; i++) load(1'b0, '0, 1'b1, DW'(6'h30 - i * 7));
    expect_push(6'h30);
    af0  = 1'b0;
    base = cyc;
    repeat (3) tick();
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    exp_q.delete();
    tick();
    reset = 1'b0;
    clear_logs();
    repeat (10) tick();
    check("f_no_push", push_cyc.size(), 0);
    check("f_no_pop", pop_vc.size(), 0);
    check("f_idle", int'(idle), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
